// File: rtl/mem_arbiter_if.sv
// Requester-side command/response bus of mem_arbiter: packed per-requester
// command fields plus the shared read-response return path.
interface mem_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lock,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lock,
    input  req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to enable req_lock / LOCKED grant holding (LOCK_MAX cycles max).
module mem_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_if.slave          bus,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [1:0]            grant_id,
  output logic                  locked
);

`ifdef MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOCKED = 2'd2} state_t;
  localparam int LOCK_CNT_W = $clog2(LOCK_MAX + 1);
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic                  lock_done;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
`endif

  state_t                state, state_nxt;
  logic [1:0]            last_grant, sel_idx, gnt_idx, cand;
  logic                  sel_found, hs;
  logic [NUM_REQ-1:0]    ready;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]            rd_id_p1, rd_id_p2;
  logic                  rd_vld_p2;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_grant;
    cand      = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(last_grant) + k) % NUM_REQ);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  assign lock_done = (lock_cnt == LOCK_CNT_W'(LOCK_MAX - 1));
`endif

  always_comb begin
    state_nxt = state;
    ready     = '0;
    gnt_idx   = sel_idx;
    case (state)
`ifdef MEM_ARB_LOCK_EN
      LOCKED: begin
        // Owner is last_grant; an idle owner still blocks everyone until expiry
        gnt_idx            = last_grant;
        ready[last_grant]  = bus.req_valid[last_grant];
        if (lock_done || (bus.req_valid[last_grant] && !bus.req_lock[last_grant]))
          state_nxt = GRANT;
      end
`endif
      IDLE, GRANT: begin
        ready[sel_idx] = sel_found;
        state_nxt      = sel_found ? GRANT : IDLE;
`ifdef MEM_ARB_LOCK_EN
        if (sel_found && bus.req_lock[sel_idx])
          state_nxt = LOCKED;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign hs            = |ready;
  assign bus.req_ready = rst ? ready : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 2'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (hs)
        last_grant <= gnt_idx;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lock_cnt <= '0;
    else if (state == LOCKED)
      lock_cnt <= lock_cnt + 1'b1;
    else
      lock_cnt <= '0;
  end
`endif

  // Stage p1: accepted command issued to the RAM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_id_p1  <= '0;
    end else begin
      ram_en <= hs;
      if (hs) begin
        ram_we    <= sel_we;
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
        rd_id_p1  <= gnt_idx;
      end
    end
  end

  // Stage p2: RAM read data returns, steered to the issuing requester
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_p2 <= 1'b0;
      rd_id_p2  <= '0;
    end else begin
      rd_vld_p2 <= ram_en & ~ram_we;
      rd_id_p2  <= rd_id_p1;
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.rsp_valid[i] = rd_vld_p2 && (rd_id_p2 == 2'(i));
  end

  assign bus.rsp_rdata = rd_vld_p2 ? ram_rdata : '0;
  assign grant_id      = last_grant;
`ifdef MEM_ARB_LOCK_EN
  assign locked = (state == LOCKED);
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a queue-based behavioural model.
// Lock scenarios are exercised only when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;
  localparam int NUM_REQ    = 3;
  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 16;
  localparam int LOCK_MAX   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic                  ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata = '0;
  logic [1:0]            grant_id;
  logic                  locked;

  mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  logic [DATA_WIDTH-1:0] ram    [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] shadow [1 << ADDR_WIDTH];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  typedef struct { int due; logic we; logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] wdata; } iss_t;
  typedef struct { int due; int id; logic [DATA_WIDTH-1:0] data; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   gnt_log[$];

  int checks = 0, failures = 0, cyc = 0;
  int m_last, m_owner, m_left;
  bit m_locked;
  logic [ADDR_WIDTH-1:0] t_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] t_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]    last_ready, obs_rsp_valid;
  logic [DATA_WIDTH-1:0] obs_rsp_data;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(int i, logic v, logic we, logic [ADDR_WIDTH-1:0] a,
                         logic [DATA_WIDTH-1:0] d, logic lk);
    logic [1:0] ix;
    ix = 2'(i);
    bus.req_valid[ix] = v;
    bus.req_we[ix]    = we;
    bus.req_lock[ix]  = lk;
    t_addr[ix]        = a;
    t_wdata[ix]       = d;
    bus.req_addr      = {t_addr[2], t_addr[1], t_addr[0]};
    bus.req_wdata     = {t_wdata[2], t_wdata[1], t_wdata[0]};
  endtask

  task automatic idle_all();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rand_req();
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ADDR_WIDTH'($urandom_range(0, 15)), DATA_WIDTH'($urandom),
              ($urandom_range(0, 7) == 0));
  endtask

  // One clock: compare at the falling edge, then advance the model
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_ready, exp_rv;
    logic [1:0] gx;
    int g, c;
    iss_t it;
    rsp_t rs;
    @(negedge clk);
    exp_ready = '0;
    g = -1;
    if (m_locked) begin
      if (bus.req_valid[2'(m_owner)]) g = m_owner;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (m_last + k) % NUM_REQ;
        if (g < 0 && bus.req_valid[2'(c)]) g = c;
      end
    end
    if (g >= 0) exp_ready[2'(g)] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("grant_id", 32'(grant_id), 32'(m_last));
    chk("locked", 32'(locked), 32'(m_locked));

    if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
      chk("ram_en", 32'(ram_en), 32'd1);
      chk("ram_we", 32'(ram_we), 32'(iss_q[0].we));
      chk("ram_addr", 32'(ram_addr), 32'(iss_q[0].addr));
      if (iss_q[0].we) chk("ram_wdata", 32'(ram_wdata), 32'(iss_q[0].wdata));
      void'(iss_q.pop_front());
    end else begin
      chk("ram_en_idle", 32'(ram_en), 32'd0);
    end

    exp_rv = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      exp_rv[2'(rsp_q[0].id)] = 1'b1;
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(rsp_q[0].data));
      void'(rsp_q.pop_front());
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));

    last_ready = bus.req_ready;
    if (|bus.rsp_valid) begin
      obs_rsp_valid = bus.rsp_valid;
      obs_rsp_data  = bus.rsp_rdata;
    end

    if (g >= 0) begin
      gx = 2'(g);
      m_last = g;
      gnt_log.push_back(g);
      it.due = cyc + 1; it.we = bus.req_we[gx]; it.addr = t_addr[gx]; it.wdata = t_wdata[gx];
      iss_q.push_back(it);
      if (bus.req_we[gx]) begin
        shadow[t_addr[gx]] = t_wdata[gx];
      end else begin
        rs.due = cyc + 2; rs.id = g; rs.data = shadow[t_addr[gx]];
        rsp_q.push_back(rs);
      end
    end
`ifdef MEM_ARB_LOCK_EN
    if (m_locked) begin
      m_left--;
      if ((g >= 0 && !bus.req_lock[2'(g)]) || m_left == 0) m_locked = 1'b0;
    end else if (g >= 0 && bus.req_lock[2'(g)]) begin
      m_locked = 1'b1;
      m_owner  = g;
      m_left   = LOCK_MAX;
    end
`endif
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    iss_q.delete();
    rsp_q.delete();
    m_last   = NUM_REQ - 1;
    m_locked = 1'b0;
    repeat (n) begin
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'($urandom_range(0, 1)), '0, '0, 1'b1);
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'(NUM_REQ - 1));
      chk("rst_locked", 32'(locked), 32'd0);
      cyc++;
      @(posedge clk);
      #1;
    end
    idle_all();
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) begin
      ram[i]    = DATA_WIDTH'(i * 7 + 3);
      shadow[i] = DATA_WIDTH'(i * 7 + 3);
    end
    ram[1] = 16'h0005; shadow[1] = 16'h0005;
    for (int i = 0; i < NUM_REQ; i++) begin t_addr[i] = '0; t_wdata[i] = '0; end
    idle_all();
    do_reset(3);

    // All requesters continuously valid straight out of reset
    gnt_log.delete();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, ADDR_WIDTH'(i + 2), '0, 1'b0);
    repeat (6) cycle();
    idle_all();
    repeat (3) cycle();
    chk("rr_count", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) chk("rr_order", 32'(gnt_log[i]), 32'(exp_order[i]));

    // Single read of a preloaded word
    obs_rsp_valid = '0; obs_rsp_data = '0;
    set_req(0, 1'b1, 1'b0, 10'h001, '0, 1'b0);
    cycle();
    idle_all();
    repeat (3) cycle();
    chk("rd1_valid", 32'(obs_rsp_valid), 32'b001);
    chk("rd1_rdata", 32'(obs_rsp_data), 32'h0005);

    // Write by requester 1, read back by requester 2
    obs_rsp_valid = '0; obs_rsp_data = '0;
    set_req(1, 1'b1, 1'b1, 10'h00F, 16'h0004, 1'b0);
    cycle();
    idle_all();
    set_req(2, 1'b1, 1'b0, 10'h00F, '0, 1'b0);
    cycle();
    idle_all();
    repeat (3) cycle();
    chk("wr_rd_valid", 32'(obs_rsp_valid), 32'b100);
    chk("wr_rd_rdata", 32'(obs_rsp_data), 32'h0004);

`ifdef MEM_ARB_LOCK_EN
    // Locked burst of three writes keeps requester 1 out
    set_req(1, 1'b1, 1'b0, 10'h000, '0, 1'b0);
    set_req(0, 1'b1, 1'b1, 10'h00E, 16'h00A1, 1'b1);
    cycle(); chk("lock_burst_r1_a", 32'(last_ready[1]), 32'd0);
    set_req(0, 1'b1, 1'b1, 10'h00F, 16'h00A2, 1'b1);
    cycle(); chk("lock_burst_r1_b", 32'(last_ready[1]), 32'd0);
    set_req(0, 1'b1, 1'b1, 10'h010, 16'h00A3, 1'b0);
    cycle(); chk("lock_burst_r1_c", 32'(last_ready[1]), 32'd0);
    set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle(); chk("lock_burst_r1_go", 32'(last_ready[1]), 32'd1);
    idle_all();
    repeat (3) cycle();

    // Owner goes silent while locked: port stalls until LOCK_MAX expiry
    set_req(0, 1'b1, 1'b0, 10'h003, '0, 1'b1);
    set_req(1, 1'b1, 1'b0, 10'h004, '0, 1'b0);
    cycle();
    set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < LOCK_MAX; k++) begin
      cycle();
      chk("lock_hold_r1", 32'(last_ready[1]), 32'd0);
    end
    cycle();
    chk("lock_expire_r1", 32'(last_ready[1]), 32'd1);
    idle_all();
    repeat (3) cycle();
`endif

    // Reset the cycle after a read is accepted: the read must vanish
    set_req(0, 1'b1, 1'b0, 10'h005, '0, 1'b0);
    cycle();
    do_reset(2);
    obs_rsp_valid = '0;
    repeat (4) cycle();
    chk("rst_drop_rsp", 32'(obs_rsp_valid), 32'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      rand_req();
      if ($urandom_range(0, 199) == 0) do_reset(2);
      else cycle();
    end
    idle_all();
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters (0 = eval core, 1 = boot loader, 2 = debug/display reader).
REQ-002 Parameter ADDR_WIDTH, default 10, RAM word address width (1024 words).
REQ-003 Parameter DATA_WIDTH, default 16, RAM word width (lisp::data_width).
REQ-004 Parameter LOCK_MAX, default 8, maximum consecutive locked grants.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester command valid.
REQ-008 req_ready  out  NUM_REQ  per-requester command accepted this cycle.
REQ-009 req_we  in  NUM_REQ  1 = write, 0 = read.
REQ-010 req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-011 req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
REQ-012 req_lock  in  NUM_REQ  hold grant after this transfer (multi-word cons/alloc).
REQ-013 rsp_valid  out  NUM_REQ  read data valid for requester i.
REQ-014 rsp_rdata  out  DATA_WIDTH  shared read data, qualified by rsp_valid.
REQ-015 ram_en, ram_we  out  1 each  RAM command strobe and write enable.
REQ-016 ram_addr  out  ADDR_WIDTH; ram_wdata  out  DATA_WIDTH  RAM command fields.
REQ-017 ram_rdata  in  DATA_WIDTH  RAM read data, valid exactly 1 cycle after ram_en with ram_we=0.
REQ-018 grant_id  out  2  last granted requester; locked  out  1  lock held.

Function
REQ-019 Each cycle at most one handshake; req_ready is combinational, asserted only for the selected requester with req_valid=1.
REQ-020 Selection is round-robin: search starts at (last_grant+1) mod NUM_REQ, wraps, first valid wins.
REQ-021 Accepted command is registered onto ram_en/ram_we/ram_addr/ram_wdata in the following cycle (1-cycle issue latency); ram_en=0 when none accepted.
REQ-022 Read accepted in cycle N: rsp_valid[i]=1 and rsp_rdata=ram_rdata in cycle N+2, one cycle only; writes produce no response.
REQ-023 Back-to-back accepts each cycle are supported (full throughput); responses return in accept order.
REQ-024 last_grant updates only on a handshake; idle cycles leave it unchanged.
REQ-025 States: IDLE (no valid), GRANT (arbitrating), LOCKED (owner fixed); IDLE->GRANT on any valid, GRANT->LOCKED on handshake with req_lock=1, LOCKED->GRANT on owner handshake with req_lock=0 or lock count reaching LOCK_MAX.
REQ-026 In LOCKED only the owner may get req_ready; owner with req_valid=0 stalls the port (no other grants) until count expiry.
REQ-027 Lock counter increments per LOCKED cycle; at LOCK_MAX lock is force-released and the owner becomes last_grant.
REQ-028 Simultaneous valid from all requesters with last_grant=2: requester 0 wins.

Reset
REQ-029 While rst=0: req_ready=0, rsp_valid=0, rsp_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, grant_id=NUM_REQ-1, locked=0, state IDLE.
REQ-030 Reset mid-operation discards in-flight reads; no rsp_valid after release for pre-reset commands.
REQ-031 First cycle after release: requester 0 has highest priority.

Configuration
REQ-032 Macro MEM_ARB_LOCK_EN: defined -> req_lock, LOCKED state and LOCK_MAX enforced as above.
REQ-033 Not defined -> req_lock ignored, LOCKED state absent, locked tied 0, pure round-robin.

Verification
REQ-034 Single read: req 0 reads addr 0x001 holding 0x0005 -> ram_en cycle N+1, rsp_valid[0]=1, rsp_rdata=0x0005 at N+2.
REQ-035 All three valid continuously after reset -> grant order 0,1,2,0,1,2; one ready per cycle.
REQ-036 Write 0x0004 to 0x00F by req 1 then read by req 2 -> rsp_rdata=0x0004 for req 2 only.
REQ-037 LOCK_EN: req 0 writes 0x00E/0x00F/0x010 with lock=1,1,0 while req 1 valid -> req 1 ready only after third write.
REQ-038 LOCK_EN: req 0 holds lock, req_valid=0 -> release after 8 cycles, req 1 granted next.
REQ-039 Reset asserted cycle after read accept -> no rsp_valid; all outputs at reset values.
